laser_mode_sequencer: RTL and testbench
=======================================

// Module: laser_mode_sequencer
// PURPOSE
//  Mode controller for the two-color laser driver. Consumes debounced push-button edge pulses and
//  classifies each press as short or long. Steps the laser mode OFF/A/B/ALT. Drives the laser A/B
//  enables with break-before-make dead time; in ALT mode it swaps lasers on each frame_sync.
//  Sits between the push-button debouncer outputs and the laser driver enable pins.
// PARAMETERS
//  LONG_PRESS_CYCLES  50_000_000  press duration (clk cycles) that counts as a long press (>=2)
//  GUARD_CYCLES       16          dead time with both lasers off before any laser turns on (>=1)
//  CNT_W              26          counter width; must hold max(LONG_PRESS_CYCLES, GUARD_CYCLES)
// PORTS
//  clk          in   1  system clock
//  rst_n        in   1  asynchronous reset, active low
//  pb_down      in   1  1-cycle pulse: button just pressed (debounced, clk-synchronous)
//  pb_up        in   1  1-cycle pulse: button just released
//  frame_sync   in   1  1-cycle pulse at each imaging frame start
//  interlock_n  in   1  clk-synchronous safety interlock; 0 = lasers forbidden
//  mode         out  2  current mode: 0 OFF, 1 A, 2 B, 3 ALT
//  frame_tag    out  1  in ALT: 0 = frame assigned to A, 1 = frame assigned to B; 0 otherwise
//  long_press   out  1  1-cycle pulse when a press reaches LONG_PRESS_CYCLES
//  laser_a_en   out  1  laser A enable
//  laser_b_en   out  1  laser B enable
// BEHAVIOUR
//  Reset: mode=0, frame_tag=0, long_press=0, laser_a_en=laser_b_en=0, classifier IDLE, sequencer S_OFF.
//  Press classifier (IDLE, PRESSED):
//   - IDLE: on pb_down, go to PRESSED; clear hold counter and the long_fired flag. pb_up is ignored.
//   - PRESSED: the hold counter increments every cycle and saturates.
//   - PRESSED: when the counter reaches LONG_PRESS_CYCLES-1, pulse long_press for one cycle and set long_fired.
//   - PRESSED: pb_down is ignored. On pb_up, go to IDLE. If long_fired=0, emit an internal short_press.
//   - pb_down and pb_up together in IDLE: treat as pb_down. Together in PRESSED: treat as pb_up.
//  Mode register (updates on the edge after the event):
//   - short_press: OFF->A->B->ALT->OFF.
//   - long_press: mode <= OFF.
//   - interlock_n=0: mode <= OFF. The classifier returns to IDLE. Events are discarded while interlock_n is low.
//   - Priority: interlock > long_press > short_press.
//  frame_tag:
//   - Cleared whenever mode!=ALT, including on the edge that enters ALT; the first ALT frame is A.
//   - In ALT, toggles on each frame_sync. A frame_sync on the entry cycle is ignored.
//  Target drive = {A} for mode A; {B} for mode B; ALT: A if frame_tag=0, else B; OFF: none.
//  Output sequencer (S_OFF, S_GUARD, S_ON), registered drive:
//   - S_OFF: drive none. If target!=none, go to S_GUARD.
//   - S_GUARD: drive none for exactly GUARD_CYCLES cycles, then go to S_ON driving the target
//     sampled in the last guard cycle.
//   - S_GUARD: if target becomes none, go to S_OFF immediately. If target changes to another laser,
//     restart the guard count.
//   - S_ON: if target=none, go to S_OFF; the drive drops on the next edge. If target is the other
//     laser, go to S_GUARD; the drive drops on the next edge.
//   - Both lasers are never enabled together, in any cycle.
//  laser_a_en/laser_b_en = registered drive AND interlock_n. Interlock cut-off is zero-latency.
//  Latency (event at cycle N, meaning pb_up or frame_sync):
//   - mode/frame_tag change at N+1.
//   - Enables drop at N+2.
//   - A newly selected laser turns on at N+2+GUARD_CYCLES.
//  A reset mid-operation drops both enables asynchronously and returns all state to reset values.
// TESTING (LONG_PRESS_CYCLES=20, GUARD_CYCLES=4)
//  1. Short press: pb_down at 0, pb_up at 5 -> mode=1 at cycle 6; laser_a_en=1 from cycle 11; long_press never pulses.
//  2. Long press from mode=2: hold 30 cycles -> one long_press pulse at 19 cycles after pb_down;
//     mode=0 on the next edge; laser_b_en drops one cycle later; pb_up causes no mode step.
//  3. ALT: 3 short presses -> mode=3, A on after guard. frame_sync -> frame_tag=1, A off at +2,
//     B on at +2+4. Check a_en&b_en==0 in every cycle.
//  4. Interlock: with laser A on, interlock_n=0 -> laser_a_en=0 the same cycle and mode=0 next edge.
//     Presses are ignored while interlock_n is low. After release, the lasers stay off until the next press.
//  5. Guard abort: press to mode B, then a long press while still in S_GUARD -> S_OFF; no enable ever pulses.
//  6. Async reset asserted mid-guard and mid-press -> all outputs 0 immediately. After release, the
//     first short press gives mode=1.

Source files
------------

// File: rtl/laser_mode_sequencer.sv
// Two-color laser mode controller. It classifies button presses as short or long, steps the
// OFF/A/B/ALT mode, and drives the laser enables with break-before-make dead time.
module laser_mode_sequencer #(
    parameter int LONG_PRESS_CYCLES = 50_000_000,
    parameter int GUARD_CYCLES      = 16,
    parameter int CNT_W             = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       pb_down,
    input  logic       pb_up,
    input  logic       frame_sync,
    input  logic       interlock_n,
    output logic [1:0] mode,
    output logic       frame_tag,
    output logic       long_press,
    output logic       laser_a_en,
    output logic       laser_b_en
);

    typedef enum logic {C_IDLE, C_PRESSED} cls_t;
    typedef enum logic [1:0] {S_OFF, S_GUARD, S_ON} seq_t;

    localparam logic [1:0] MODE_OFF = 2'd0;
    localparam logic [1:0] MODE_ALT = 2'd3;
    localparam logic [1:0] DRV_NONE = 2'b00;
    localparam logic [1:0] DRV_A    = 2'b01;
    localparam logic [1:0] DRV_B    = 2'b10;

    // The pulse is combinational on the cycle before the counter reaches LONG_PRESS_CYCLES-1.
    // This places it LONG_PRESS_CYCLES-1 cycles after the pb_down cycle.
    localparam logic [CNT_W-1:0] LONG_HIT   = CNT_W'(LONG_PRESS_CYCLES - 2);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    cls_t             cls_state;
    logic [CNT_W-1:0] hold_cnt;
    logic             long_fired;
    seq_t             seq_state;
    logic [CNT_W-1:0] guard_cnt;
    logic [1:0]       guard_tgt;
    logic [1:0]       drive;

    logic             pressed;
    logic             short_press;
    logic [1:0]       mode_next;
    logic [1:0]       target;

    assign pressed     = (cls_state == C_PRESSED);
    assign long_press  = interlock_n && pressed && !long_fired && (hold_cnt == LONG_HIT);
    assign short_press = interlock_n && pressed && pb_up && !long_fired;

    always_comb begin
        mode_next = mode;
        if (!interlock_n || long_press)
            mode_next = MODE_OFF;
        else if (short_press)
            mode_next = mode + 2'd1;
    end

    always_comb begin
        target = DRV_NONE;
        case (mode)
            2'd1:    target = DRV_A;
            2'd2:    target = DRV_B;
            2'd3:    target = frame_tag ? DRV_B : DRV_A;
            default: target = DRV_NONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_state  <= C_IDLE;
            hold_cnt   <= '0;
            long_fired <= 1'b0;
        end else if (!interlock_n) begin
            cls_state <= C_IDLE;
        end else begin
            case (cls_state)
                C_IDLE: if (pb_down) begin
                    cls_state  <= C_PRESSED;
                    hold_cnt   <= '0;
                    long_fired <= 1'b0;
                end
                C_PRESSED: begin
                    if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
                    if (long_press) long_fired <= 1'b1;
                    if (pb_up) cls_state <= C_IDLE;
                end
                default: cls_state <= C_IDLE;
            endcase
        end
    end

    // The tag only toggles while ALT persists across the edge, so entering ALT always starts on A.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode      <= MODE_OFF;
            frame_tag <= 1'b0;
        end else begin
            mode      <= mode_next;
            frame_tag <= (mode == MODE_ALT && mode_next == MODE_ALT) ? (frame_tag ^ frame_sync) : 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_state <= S_OFF;
            guard_cnt <= '0;
            guard_tgt <= DRV_NONE;
            drive     <= DRV_NONE;
        end else begin
            case (seq_state)
                S_OFF: begin
                    drive <= DRV_NONE;
                    if (target != DRV_NONE) begin
                        seq_state <= S_GUARD;
                        guard_cnt <= '0;
                        guard_tgt <= target;
                    end
                end
                S_GUARD: begin
                    drive <= DRV_NONE;
                    if (target == DRV_NONE) begin
                        seq_state <= S_OFF;
                    end else if (target != guard_tgt) begin
                        guard_tgt <= target;
                        guard_cnt <= '0;
                    end else if (guard_cnt == GUARD_LAST) begin
                        seq_state <= S_ON;
                        drive     <= target;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                S_ON: begin
                    if (target == DRV_NONE) begin
                        seq_state <= S_OFF;
                        drive     <= DRV_NONE;
                    end else if (target != drive) begin
                        seq_state <= S_GUARD;
                        drive     <= DRV_NONE;
                        guard_cnt <= '0;
                        guard_tgt <= target;
                    end
                end
                default: begin
                    seq_state <= S_OFF;
                    drive     <= DRV_NONE;
                end
            endcase
        end
    end

    // Interlock gating is combinational so a cut-off takes effect in the same cycle.
    assign laser_a_en = drive[0] & interlock_n;
    assign laser_b_en = drive[1] & interlock_n;

endmodule

// File: tb/tb_laser_mode_sequencer.sv
// Directed bench for laser_mode_sequencer (LONG_PRESS_CYCLES=20, GUARD_CYCLES=4).
// A second instance with a long guard covers the guard-abort case.
module tb_laser_mode_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pb_down = 1'b0, pb_up = 1'b0, frame_sync = 1'b0, interlock_n = 1'b1;
    logic [1:0] mode, mode2;
    logic       frame_tag, long_press, laser_a_en, laser_b_en;
    logic       frame_tag2, long_press2, laser_a_en2, laser_b_en2;

    int checks = 0;
    int errors = 0;
    int both_cnt = 0;
    int lp_count = 0;
    int e2_seen = 0;
    int lp0 = 0;
    logic arm2 = 1'b0;

    always #5 clk = ~clk;

    laser_mode_sequencer #(.LONG_PRESS_CYCLES(20), .GUARD_CYCLES(4), .CNT_W(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up), .frame_sync(frame_sync),
        .interlock_n(interlock_n), .mode(mode), .frame_tag(frame_tag), .long_press(long_press),
        .laser_a_en(laser_a_en), .laser_b_en(laser_b_en)
    );

    laser_mode_sequencer #(.LONG_PRESS_CYCLES(20), .GUARD_CYCLES(32), .CNT_W(8)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .pb_down(pb_down), .pb_up(pb_up), .frame_sync(frame_sync),
        .interlock_n(interlock_n), .mode(mode2), .frame_tag(frame_tag2), .long_press(long_press2),
        .laser_a_en(laser_a_en2), .laser_b_en(laser_b_en2)
    );

    always @(negedge clk) begin
        if ((laser_a_en && laser_b_en) || (laser_a_en2 && laser_b_en2)) both_cnt++;
        if (long_press) lp_count++;
        if (arm2 && (laser_a_en2 || laser_b_en2)) e2_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n clock edges; one-cycle pulses set beforehand are cleared after the first edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            pb_down = 1'b0;
            pb_up = 1'b0;
            frame_sync = 1'b0;
        end
    endtask

    task automatic short_press();
        pb_down = 1'b1;
        cyc(1);
        pb_up = 1'b1;
        cyc(1);
    endtask

    initial begin
        // Reset state
        cyc(2);
        check("rst_mode", mode, 0);
        check("rst_tag", frame_tag, 0);
        check("rst_lp", long_press, 0);
        check("rst_a", laser_a_en, 0);
        check("rst_b", laser_b_en, 0);
        rst_n = 1'b1;
        cyc(2);

        // 1. Short press: pb_down at 0, pb_up at 5
        pb_down = 1'b1;
        cyc(5);
        check("t1_mode_before_up", mode, 0);
        pb_up = 1'b1;
        cyc(1);
        check("t1_mode_a", mode, 1);
        cyc(4);
        check("t1_a_in_guard", laser_a_en, 0);
        cyc(1);
        check("t1_a_on", laser_a_en, 1);
        check("t1_b_off", laser_b_en, 0);
        check("t1_no_long", lp_count, 0);

        // 2. Long press from mode B
        short_press();
        check("t2_mode_b", mode, 2);
        cyc(6);
        check("t2_b_on", laser_b_en, 1);
        check("t2_a_off", laser_a_en, 0);
        lp0 = lp_count;
        pb_down = 1'b1;
        cyc(18);
        check("t2_lp_early", long_press, 0);
        cyc(1);
        check("t2_lp_pulse", long_press, 1);
        check("t2_mode_hold", mode, 2);
        cyc(1);
        check("t2_lp_single", long_press, 0);
        check("t2_mode_off", mode, 0);
        check("t2_b_still", laser_b_en, 1);
        cyc(1);
        check("t2_b_drop", laser_b_en, 0);
        cyc(9);
        pb_up = 1'b1;
        cyc(1);
        check("t2_no_step", mode, 0);
        check("t2_lp_count", lp_count, lp0 + 1);

        // 3. ALT: three short presses, then frame swaps
        short_press();
        short_press();
        short_press();
        check("t3_mode_alt", mode, 3);
        check("t3_tag0", frame_tag, 0);
        cyc(4);
        check("t3_a_guard", laser_a_en, 0);
        cyc(1);
        check("t3_a_on", laser_a_en, 1);
        frame_sync = 1'b1;
        cyc(1);
        check("t3_tag1", frame_tag, 1);
        check("t3_a_hold", laser_a_en, 1);
        cyc(1);
        check("t3_a_drop", laser_a_en, 0);
        check("t3_b_off", laser_b_en, 0);
        cyc(3);
        check("t3_b_guard", laser_b_en, 0);
        cyc(1);
        check("t3_b_on", laser_b_en, 1);
        frame_sync = 1'b1;
        cyc(1);
        check("t3_tag_back", frame_tag, 0);
        cyc(5);
        check("t3_a_again", laser_a_en, 1);

        // 4. Interlock: zero-latency cut-off, then presses are ignored
        interlock_n = 1'b0;
        pb_down = 1'b1;
        #1;
        check("t4_a_cut", laser_a_en, 0);
        check("t4_mode_same", mode, 3);
        cyc(1);
        check("t4_mode_off", mode, 0);
        pb_up = 1'b1;
        cyc(1);
        short_press();
        check("t4_ignored", mode, 0);
        interlock_n = 1'b1;
        cyc(8);
        check("t4_still_off", mode, 0);
        check("t4_a_stay_off", laser_a_en, 0);
        check("t4_b_stay_off", laser_b_en, 0);
        short_press();
        check("t4_next_press", mode, 1);

        // 6. Async reset mid-guard and mid-press
        cyc(1);
        pb_down = 1'b1;
        cyc(1);
        #3;
        rst_n = 1'b0;
        #1;
        check("t6_mode", mode, 0);
        check("t6_tag", frame_tag, 0);
        check("t6_lp", long_press, 0);
        check("t6_a", laser_a_en, 0);
        check("t6_b", laser_b_en, 0);
        cyc(2);
        rst_n = 1'b1;
        arm2 = 1'b1;
        cyc(1);
        short_press();
        check("t6_first_press", mode, 1);

        // 5. Guard abort on the long-guard instance: long press while still guarding
        short_press();
        check("t5_mode_b", mode2, 2);
        pb_down = 1'b1;
        cyc(19);
        check("t5_lp", long_press2, 1);
        cyc(1);
        check("t5_mode_off", mode2, 0);
        pb_up = 1'b1;
        cyc(5);
        check("t5_a2_off", laser_a_en2, 0);
        check("t5_b2_off", laser_b_en2, 0);
        check("t5_no_enable", e2_seen, 0);

        check("both_never_on", both_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
